// File: rtl/uart_tx_queue_if.sv
// Producer-side and transmitter-side signals of uart_tx_queue.
// UART_TXQ_OVERFLOW_EN adds the sticky overflow flag and its clear input.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              tx_done;
    logic              tx_enabled;
    logic [DATA_W-1:0] tx_data;
`ifdef UART_TXQ_OVERFLOW_EN
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output wr_en, wr_data, tx_done, ovf_clr,
        input  full, empty, count, tx_enabled, tx_data, overflow
    );
    modport slave (
        input  wr_en, wr_data, tx_done, ovf_clr,
        output full, empty, count, tx_enabled, tx_data, overflow
    );
`else
    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, count, tx_enabled, tx_data
    );
    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, count, tx_enabled, tx_data
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus dispatch FSM feeding a UART transmitter one byte per frame.
// Optional macro UART_TXQ_OVERFLOW_EN adds a sticky overflow flag with ovf_clr.
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic           clk,
    input  logic           rstN,
    uart_tx_queue_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic [1:0]        r_state;
    logic              r_tx_enabled;
    logic [DATA_W-1:0] r_tx_data;

    logic [1:0]        w_state_nxt;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;

    // Full is judged on the start-of-cycle flag, so a same-cycle pop never rescues a push.
    assign w_push      = bus.wr_en && !r_full;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Dispatch FSM: pop on leaving IDLE, pulse in LAUNCH, hold until the frame ends.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH:    w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // tx_data is captured at pop time and held for the whole frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tx_enabled <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            r_tx_enabled <= (w_state_nxt == S_LAUNCH);
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic r_overflow;

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_overflow <= 1'b0;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end else if (bus.wr_en && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`endif

    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.count      = r_count;
    assign bus.tx_enabled = r_tx_enabled;
    assign bus.tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: queue-based reference model plus decoupled monitor.
// Build with +define+UART_TXQ_OVERFLOW_EN to also check the overflow flag.
module tb_uart_tx_queue;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

    uart_tx_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, frame phase (0 idle, 1 launching, 2 awaiting done).
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_txdata;
    int         m_phase;
`ifdef UART_TXQ_OVERFLOW_EN
    bit         m_ovf;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_fifo.delete();
            exp_q.delete();
            m_txdata = 8'h00;
            m_phase  = 0;
`ifdef UART_TXQ_OVERFLOW_EN
            m_ovf    = 1'b0;
`endif
        end else begin
            int occ;
            occ = m_fifo.size();
            if (m_phase == 0 && occ != 0) begin
                m_txdata = m_fifo.pop_front();
                exp_q.push_back(m_txdata);
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && bus.tx_done) begin
                m_phase = 0;
            end
            if (bus.wr_en && occ < int'(DEPTH)) begin
                m_fifo.push_back(bus.wr_data);
            end
`ifdef UART_TXQ_OVERFLOW_EN
            if (bus.ovf_clr) begin
                m_ovf = 1'b0;
            end else if (bus.wr_en && occ == int'(DEPTH)) begin
                m_ovf = 1'b1;
            end
`endif
        end
    end

    // Monitor: status against the model every cycle, launched bytes against the scoreboard.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            chk("count", 32'(bus.count), 32'(m_fifo.size()));
            chk("full", 32'(bus.full), 32'(m_fifo.size() == int'(DEPTH)));
            chk("empty", 32'(bus.empty), 32'(m_fifo.size() == 0));
            chk("tx_enabled", 32'(bus.tx_enabled), 32'(m_phase == 1));
            chk("tx_data_hold", 32'(bus.tx_data), 32'(m_txdata));
`ifdef UART_TXQ_OVERFLOW_EN
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`endif
            if (bus.tx_enabled === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL launch_unexpected actual=%0h expected=none at %0t", bus.tx_data, $time);
                end else begin
                    chk("launch_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit wr, input logic [7:0] d, input bit done);
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.tx_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_fifo.size() != 0 || m_phase != 0) && n < 2000) begin
            step(1'b0, 8'h00, m_phase == 2);
            n++;
        end
        chk("drain_bound", 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (m_phase != 2 && n < 100) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("frame_bound", 32'(n < 100), 32'd1);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_done = 1'b0;
`ifdef UART_TXQ_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_tx_enabled", 32'(bus.tx_enabled), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rstN = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Single byte: pulse exactly two cycles after the push cycle.
        step(1'b1, 8'hA5, 1'b0);
        chk("lat_c1_tx_enabled", 32'(bus.tx_enabled), 32'd0);
        chk("lat_c1_count", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_c2_tx_enabled", 32'(bus.tx_enabled), 32'd1);
        chk("lat_c2_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("lat_c2_count", 32'(bus.count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_c3_tx_enabled", 32'(bus.tx_enabled), 32'd0);
        repeat (6) step(1'b0, 8'h00, 1'b0);
        drain();

        // Burst to full, then drops while full (with and without a same-cycle pop).
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        chk("burst_count", 32'(bus.count), 32'd15);
        step(1'b1, 8'h11, 1'b0);
        chk("burst_full", 32'(bus.full), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        chk("drop_count", 32'(bus.count), 32'd16);
`ifdef UART_TXQ_OVERFLOW_EN
        chk("ovf_set", 32'(bus.overflow), 32'd1);
`endif
        wait_frame();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hEE, 1'b0);
        chk("drop_with_pop_count", 32'(bus.count), 32'd15);
        drain();
        chk("burst_empty", 32'(bus.empty), 32'd1);
`ifdef UART_TXQ_OVERFLOW_EN
        bus.ovf_clr = 1'b1;
        step(1'b1, 8'h00, 1'b0);
        bus.ovf_clr = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        drain();
`endif

        // Steady state: keep a few entries queued over 40 frames so pointers wrap.
        repeat (3) step(1'b1, 8'($urandom), 1'b0);
        for (int f = 0; f < 40; f++) begin
            wait_frame();
            step(1'b1, 8'($urandom), 1'b1);
        end
        drain();

        // Reset in the middle of a frame with bytes still queued.
        repeat (4) step(1'b1, 8'($urandom), 1'b0);
        wait_frame();
        rstN = 1'b0;
        #1;
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_tx_enabled", 32'(bus.tx_enabled), 32'd0);
        chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        // Spurious tx_done with an empty queue must not launch anything.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'($urandom));
        end
        chk("spurious_done_idle", 32'(bus.tx_enabled), 32'd0);

        // Random traffic with random done pulses, drops and clears.
        for (int i = 0; i < 600; i++) begin
`ifdef UART_TXQ_OVERFLOW_EN
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0);
        end
`ifdef UART_TXQ_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif
        drain();
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
